// File: rtl/rv_pkg.sv
// Shared widths, forwarding-select encoding and output payload for operand_fetch.
// Build option: define OF_FORWARD_EN to build the EX/MEM/WB forwarding network.
package rv_pkg;

   localparam int XLEN = 32;
   localparam int RAW  = 5;

`ifdef OF_FORWARD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EX  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] op1;
      logic [XLEN-1:0] op2;
      logic [RAW-1:0]  rd;
      logic            rd_we;
      logic            is_load;
   } of_out_t;

endpackage

// File: rtl/of_fwd_mux.sv
// One operand's hazard detection and EX > MEM > WB > register-file select.
// Without OF_FORWARD_EN the select is pinned to the register file and any in-flight producer stalls.
module of_fwd_mux
   import rv_pkg::*;
(
   input  logic [RAW-1:0]  i_rs,
   input  logic            i_used,
   input  logic [XLEN-1:0] i_rf_rdata,
   input  logic [RAW-1:0]  i_ex_rd,
   input  logic            i_ex_we,
   input  logic            i_ex_is_load,
   input  logic [XLEN-1:0] i_ex_result,
   input  logic [RAW-1:0]  i_mem_rd,
   input  logic            i_mem_we,
   input  logic [XLEN-1:0] i_mem_result,
   input  logic [RAW-1:0]  i_wb_rd,
   input  logic            i_wb_we,
   input  logic [XLEN-1:0] i_wb_data,
   output logic [XLEN-1:0] o_data,
   output logic            o_stall
);

   logic     w_nz;
   logic     w_ex_hit;
   logic     w_mem_hit;
   logic     w_wb_hit;
   fwd_sel_e w_sel;

   assign w_nz      = (i_rs != '0);
   assign w_ex_hit  = i_ex_we  && (i_ex_rd  == i_rs) && w_nz;
   assign w_mem_hit = i_mem_we && (i_mem_rd == i_rs) && w_nz;
   assign w_wb_hit  = i_wb_we  && (i_wb_rd  == i_rs) && w_nz;

   // A load in EX has no data yet, so it never wins the select.
   always_comb begin
      // NOTE: default assigned first so every path drives w_sel and no latch is inferred.
      w_sel = FWD_RF;
      if (FWD_EN) begin
         if (w_ex_hit && !i_ex_is_load) w_sel = FWD_EX;
         else if (w_mem_hit)            w_sel = FWD_MEM;
         else if (w_wb_hit)             w_sel = FWD_WB;
      end
   end

   always_comb begin
      o_data = i_rf_rdata;
      case (w_sel)
         FWD_EX:  o_data = i_ex_result;
         FWD_MEM: o_data = i_mem_result;
         FWD_WB:  o_data = i_wb_data;
         default: o_data = i_rf_rdata;
      endcase
      if (!w_nz) o_data = '0;
   end

   assign o_stall = i_used && (FWD_EN ? (w_ex_hit && i_ex_is_load)
                                      : (w_ex_hit || w_mem_hit || w_wb_hit));

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute operand stage: RF read, RAW forwarding, load-use stall, one-entry output register.
// Forwarding is built only when OF_FORWARD_EN is defined (see of_fwd_mux).
module operand_fetch
   import rv_pkg::*;
(
   input  logic            CLK,
   input  logic            RST,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [RAW-1:0]  in_rs1,
   input  logic [RAW-1:0]  in_rs2,
   input  logic            in_rs1_used,
   input  logic            in_rs2_used,
   input  logic [RAW-1:0]  in_rd,
   input  logic            in_rd_we,
   input  logic            in_is_load,
   output logic [RAW-1:0]  rf_raddr1,
   output logic [RAW-1:0]  rf_raddr2,
   input  logic [XLEN-1:0] rf_rdata1,
   input  logic [XLEN-1:0] rf_rdata2,
   input  logic [RAW-1:0]  ex_rd,
   input  logic            ex_we,
   input  logic            ex_is_load,
   input  logic [XLEN-1:0] ex_result,
   input  logic [RAW-1:0]  mem_rd,
   input  logic            mem_we,
   input  logic [XLEN-1:0] mem_result,
   input  logic [RAW-1:0]  wb_rd,
   input  logic            wb_we,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_op1,
   output logic [XLEN-1:0] out_op2,
   output logic [RAW-1:0]  out_rd,
   output logic            out_rd_we,
   output logic            out_is_load
);

   logic [XLEN-1:0] w_op1;
   logic [XLEN-1:0] w_op2;
   logic            w_stall1;
   logic            w_stall2;
   logic            w_hz;
   logic            w_accept;
   of_out_t         w_next;
   of_out_t         r_out;
   logic            r_valid;

   assign rf_raddr1 = in_rs1;
   assign rf_raddr2 = in_rs2;

   of_fwd_mux u_fwd_rs1 (
      .i_rs         (in_rs1),
      .i_used       (in_rs1_used),
      .i_rf_rdata   (rf_rdata1),
      .i_ex_rd      (ex_rd),
      .i_ex_we      (ex_we),
      .i_ex_is_load (ex_is_load),
      .i_ex_result  (ex_result),
      .i_mem_rd     (mem_rd),
      .i_mem_we     (mem_we),
      .i_mem_result (mem_result),
      .i_wb_rd      (wb_rd),
      .i_wb_we      (wb_we),
      .i_wb_data    (wb_data),
      .o_data       (w_op1),
      .o_stall      (w_stall1)
   );

   of_fwd_mux u_fwd_rs2 (
      .i_rs         (in_rs2),
      .i_used       (in_rs2_used),
      .i_rf_rdata   (rf_rdata2),
      .i_ex_rd      (ex_rd),
      .i_ex_we      (ex_we),
      .i_ex_is_load (ex_is_load),
      .i_ex_result  (ex_result),
      .i_mem_rd     (mem_rd),
      .i_mem_we     (mem_we),
      .i_mem_result (mem_result),
      .i_wb_rd      (wb_rd),
      .i_wb_we      (wb_we),
      .i_wb_data    (wb_data),
      .o_data       (w_op2),
      .o_stall      (w_stall2)
   );

   assign w_hz     = in_valid && (w_stall1 || w_stall2);
   assign in_ready = !w_hz && (!r_valid || out_ready);
   assign w_accept = in_valid && in_ready && !flush;

   assign w_next = '{pc:      in_pc,
                     op1:     w_op1,
                     op2:     w_op2,
                     rd:      in_rd,
                     rd_we:   in_rd_we,
                     is_load: in_is_load};

   // Flush beats capture and drain; a held entry is only ever overwritten by a fresh capture.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         // NOTE: non-blocking assignments so valid and payload all change together at the edge.
         r_valid <= 1'b0;
         r_out   <= '0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_out   <= w_next;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid   = r_valid;
   assign out_pc      = r_out.pc;
   assign out_op1     = r_out.op1;
   assign out_op2     = r_out.op2;
   assign out_rd      = r_out.rd;
   assign out_rd_we   = r_out.rd_we;
   assign out_is_load = r_out.is_load;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: driver pushes expected payloads, monitor pops on each EX handshake.
// The reference model follows OF_FORWARD_EN the same way the design does.
module tb_operand_fetch;

   logic        CLK, RST, flush;
   logic        in_valid, in_ready;
   logic [31:0] in_pc;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic        in_rs1_used, in_rs2_used, in_rd_we, in_is_load;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [31:0] rf_rdata1, rf_rdata2;
   logic [4:0]  ex_rd, mem_rd, wb_rd;
   logic        ex_we, ex_is_load, mem_we, wb_we;
   logic [31:0] ex_result, mem_result, wb_data;
   logic        out_valid, out_ready;
   logic [31:0] out_pc, out_op1, out_op2;
   logic [4:0]  out_rd;
   logic        out_rd_we, out_is_load;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  rd;
      logic        rd_we;
      logic        ld;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] regs[32];
   bit          m_valid;
   bit          pend;
   int          n_checks;
   int          n_err;

   operand_fetch dut (
      .CLK(CLK), .RST(RST), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used),
      .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_result(ex_result),
      .mem_rd(mem_rd), .mem_we(mem_we), .mem_result(mem_result),
      .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
      .out_rd_we(out_rd_we), .out_is_load(out_is_load)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   // Register file: commits the WB write at the edge, x0 reads zero.
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'h0 : (32'hA500_0000 | i);
      end else if (wb_we && wb_rd != 5'd0) begin
         regs[wb_rd] <= wb_data;
      end
   end

   always_comb begin
      rf_rdata1 = regs[rf_raddr1];
      rf_rdata2 = regs[rf_raddr2];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic bound_fail(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: bound expired at t=%0t", name, $time);
   endtask

   function automatic bit producer_hit(input logic we, input logic [4:0] rd);
      return we && rd != 5'd0 &&
             ((in_rs1_used && rd == in_rs1) || (in_rs2_used && rd == in_rs2));
   endfunction

   function automatic bit model_hz();
`ifdef OF_FORWARD_EN
      return in_valid && ex_is_load && producer_hit(ex_we, ex_rd);
`else
      return in_valid && (producer_hit(ex_we, ex_rd) || producer_hit(mem_we, mem_rd) ||
                          producer_hit(wb_we, wb_rd));
`endif
   endfunction

   // Newest producer wins; a load in EX has no value to give.
   function automatic logic [31:0] resolve(input logic [4:0] rs);
      if (rs == 5'd0) return 32'h0;
`ifdef OF_FORWARD_EN
      if (ex_we && !ex_is_load && ex_rd == rs) return ex_result;
      if (mem_we && mem_rd == rs) return mem_result;
      if (wb_we && wb_rd == rs) return wb_data;
`endif
      return regs[rs];
   endfunction

   // Called at a negedge with inputs set; evaluates this cycle and returns at the next negedge.
   task automatic tick();
      bit   rdy, acc;
      exp_t e;
      #1;
      if (!RST) begin
         rdy = !model_hz() && (!m_valid || out_ready);
         check("in_ready", in_ready, rdy);
         check("out_valid", out_valid, m_valid);
         check("rf_raddr1", rf_raddr1, in_rs1);
         check("rf_raddr2", rf_raddr2, in_rs2);
         acc = in_valid && rdy && !flush;
         if (acc) begin
            e.pc = in_pc; e.op1 = resolve(in_rs1); e.op2 = resolve(in_rs2);
            e.rd = in_rd; e.rd_we = in_rd_we; e.ld = in_is_load;
            exp_q.push_back(e);
         end
         if (flush) begin
            if (m_valid) void'(exp_q.pop_front());
            m_valid = 1'b0;
         end else if (acc) begin
            m_valid = 1'b1;
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
         end
         pend = in_valid && !rdy;
      end
      @(negedge CLK);
   endtask

   // Monitor: an EX handshake at the coming edge retires the oldest expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         #2;
         if (!RST && out_valid && out_ready && !flush) begin
            if (exp_q.size() == 0) begin
               bound_fail("unexpected_output");
            end else begin
               e = exp_q.pop_front();
               check("out_pc", out_pc, e.pc);
               check("out_op1", out_op1, e.op1);
               check("out_op2", out_op2, e.op2);
               check("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
               check("out_rd_we", out_rd_we, e.rd_we);
               check("out_is_load", out_is_load, e.ld);
            end
         end
      end
   end

   task automatic set_idle();
      ex_we = 0; ex_is_load = 0; ex_rd = 0; ex_result = $urandom;
      mem_we = 0; mem_rd = 0; mem_result = $urandom;
      wb_we = 0; wb_rd = 0; wb_data = $urandom;
      flush = 0; out_ready = 1;
   endtask

   task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                            input logic we, input logic ld);
      in_valid = 1; in_pc = pc; in_rs1 = rs1; in_rs1_used = u1; in_rs2 = rs2; in_rs2_used = u2;
      in_rd = rd; in_rd_we = we; in_is_load = ld;
   endtask

   // Let a pending instruction through with quiet stages, then drain the output register.
   task automatic settle();
      int n = 0;
      set_idle();
      while (pend && n < 10) begin
         tick();
         n++;
      end
      if (pend) bound_fail("settle_accept");
      in_valid = 0;
      pend = 0;
      tick();
      tick();
   endtask

   initial begin
      n_checks = 0; n_err = 0; m_valid = 0; pend = 0;
      RST = 1; in_valid = 0; in_pc = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_used = 0; in_rs2_used = 0;
      in_rd = 0; in_rd_we = 0; in_is_load = 0;
      set_idle();
      repeat (2) @(negedge CLK);
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_out_pc", out_pc, 32'h0);
      check("reset_out_op1", out_op1, 32'h0);
      check("reset_out_op2", out_op2, 32'h0);
      check("reset_out_rd_we", {out_rd_we, out_is_load, out_rd}, 7'h0);
      RST = 0;
      tick();

      // EX forwarding of rs1
      set_instr(32'h100, 5'd5, 1, 5'd6, 1, 5'd1, 1, 0);
      ex_rd = 5'd5; ex_we = 1; ex_result = 32'hAA;
      tick();
      settle();

      // Priority across all three stages, then with EX disabled
      set_instr(32'h104, 5'd0, 0, 5'd7, 1, 5'd2, 1, 0);
      ex_rd = 7; ex_we = 1; ex_result = 32'h1;
      mem_rd = 7; mem_we = 1; mem_result = 32'h2;
      wb_rd = 7; wb_we = 1; wb_data = 32'h3;
      tick();
      settle();
      set_instr(32'h108, 5'd0, 0, 5'd7, 1, 5'd2, 1, 0);
      ex_rd = 7; ex_we = 0; ex_result = 32'h1;
      mem_rd = 7; mem_we = 1; mem_result = 32'h2;
      wb_rd = 7; wb_we = 1; wb_data = 32'h3;
      tick();
      settle();

      // x0 ignores a stage writing register 0
      set_instr(32'h10C, 5'd0, 1, 5'd0, 1, 5'd0, 0, 0);
      ex_rd = 0; ex_we = 1; ex_result = 32'hFF;
      tick();
      settle();

      // Load-use stall, then the loaded value arrives from MEM
      set_instr(32'h110, 5'd4, 0, 5'd3, 1, 5'd8, 1, 1);
      ex_rd = 3; ex_we = 1; ex_is_load = 1;
      tick();
      set_idle();
      mem_rd = 3; mem_we = 1; mem_result = 32'h55;
      tick();
      settle();

      // Backpressure for three cycles, then flush with a valid input
      set_idle();
      out_ready = 0;
      set_instr(32'h200, 5'd9, 1, 5'd10, 1, 5'd11, 1, 0);
      tick();
      set_instr(32'h300, 5'd12, 1, 5'd13, 1, 5'd14, 1, 0);
      repeat (3) begin
         if (exp_q.size() != 0) begin
            check("hold_pc", out_pc, exp_q[0].pc);
            check("hold_op1", out_op1, exp_q[0].op1);
            check("hold_op2", out_op2, exp_q[0].op2);
         end else begin
            bound_fail("hold_entry_missing");
         end
         tick();
      end
      flush = 1; out_ready = 1;
      tick();
      flush = 0; in_valid = 0; pend = 0;
      tick();

      // Asynchronous reset in the middle of a cycle while an entry is held
      set_idle();
      out_ready = 0;
      set_instr(32'h400, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0);
      tick();
      in_valid = 0;
      @(posedge CLK);
      #3;
      RST = 1;
      #1;
      check("midrst_out_valid", out_valid, 1'b0);
      check("midrst_out_op1", out_op1, 32'h0);
      check("midrst_out_pc", out_pc, 32'h0);
      exp_q.delete();
      m_valid = 0;
      pend = 0;
      @(negedge CLK);
      RST = 0;
      set_idle();
      tick();

      // Randomized traffic with small register indices to provoke hazards
      for (int c = 0; c < 600; c++) begin
         if (!pend) begin
            in_valid = ($urandom_range(0, 9) < 8);
            in_pc = $urandom;
            in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
            in_rs1_used = 1'($urandom_range(0, 1)); in_rs2_used = 1'($urandom_range(0, 1));
            in_rd = 5'($urandom_range(0, 31)); in_rd_we = 1'($urandom_range(0, 1));
            in_is_load = 1'($urandom_range(0, 1));
         end
         ex_rd = 5'($urandom_range(0, 7)); ex_we = ($urandom_range(0, 2) == 0);
         ex_is_load = ($urandom_range(0, 3) == 0); ex_result = $urandom;
         mem_rd = 5'($urandom_range(0, 7)); mem_we = ($urandom_range(0, 2) == 0); mem_result = $urandom;
         wb_rd = 5'($urandom_range(0, 7)); wb_we = ($urandom_range(0, 2) == 0); wb_data = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 29) == 0);
         tick();
      end

      settle();
      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode-to-execute operand stage directly downstream of the register file.
- Drives register-file read addresses, takes the combinational read data, and resolves RAW hazards by forwarding from EX, MEM and WB.
- Stalls on load-use hazards.
- Registers the resolved operands into a one-entry valid/ready output register that feeds the execute stage.

Parameters:
- XLEN, 32, datapath width.
- RAW, 5, register address width (32 architectural registers; x0 hard-wired to zero).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- flush  in  1  kill the output register (branch/trap redirect).
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_pc  in  XLEN  instruction PC.
- in_rs1, in_rs2  in  RAW  source register indices.
- in_rs1_used, in_rs2_used  in  1  the source is actually read.
- in_rd  in  RAW  destination index.
- in_rd_we  in  1  instruction writes rd.
- in_is_load  in  1  instruction is a load.
- rf_raddr1, rf_raddr2  out  RAW  register-file read addresses; equal in_rs1/in_rs2 combinationally.
- rf_rdata1, rf_rdata2  in  XLEN  register-file read data, combinational; x0 reads 0.
- ex_rd, ex_we, ex_is_load  in  RAW/1/1  destination of the instruction now in EX.
- ex_result  in  XLEN  EX ALU result, valid this cycle when ex_we && !ex_is_load.
- mem_rd, mem_we  in  RAW/1  MEM-stage destination.
- mem_result  in  XLEN  MEM-stage data, including load data.
- wb_rd, wb_we  in  RAW/1  WB-stage destination; this is the same write the register file commits at the next edge.
- wb_data  in  XLEN  WB write data.
- out_valid  out  1  operands valid for EX.
- out_ready  in  1  EX accepts.
- out_pc  out  XLEN  registered PC.
- out_op1, out_op2  out  XLEN  registered resolved operands.
- out_rd  out  RAW  registered destination index.
- out_rd_we  out  1  registered write enable.
- out_is_load  out  1  registered load flag.

Behaviour:
- Reset (RST high, asynchronous): out_valid=0 and every other registered output = 0. Reset mid-transfer drops the held entry.
- Forwarding, per operand, combinational. Priority EX > MEM > WB > register file.
  - A stage matches when: its we=1, its rd equals the source index, and the source index is not 0.
  - An EX match with ex_is_load=1 is not forwardable.
  - Source index 0 always yields 0, regardless of stage writes.
  - WB forwarding is mandatory: the register file writes on the clock edge, so a same-cycle read returns stale data.
- Load-use hazard: hz = in_valid && ex_we && ex_is_load && ex_rd!=0 && ((in_rs1_used && ex_rd==in_rs1) || (in_rs2_used && ex_rd==in_rs2)).
- Ready: in_ready = !hz && (!out_valid || out_ready).
- Capture: on an edge with in_valid && in_ready && !flush, load all out_* with the resolved operands and set out_valid=1. Latency is one cycle from acceptance to out_valid.
- Drain without refill: out_valid && out_ready && !(in_valid && in_ready) at the edge, then out_valid=0 (bubble).
- Hazard: hz=1 means no capture, and out_valid clears if EX consumed the entry. The instruction stays at the input; upstream must hold in_* stable while in_ready=0.
- Backpressure: out_valid && !out_ready means all out_* are held stable and in_ready=0.
- flush=1: at the next edge out_valid=0 and no capture occurs, even when in_valid && in_ready. Flush has priority over all other events.
- Operands are resolved in the cycle of capture. A held entry is never re-resolved, so stalls must not corrupt it.

Optional Feature:
- Macro OF_FORWARD_EN.
- Defined: full EX/MEM/WB forwarding as specified above.
- Undefined:
  - No forwarding paths are built; operands come from the register file only.
  - hz widens to any used-source match against EX, MEM or WB (we=1, rd!=0).
  - The stage stalls until the producer has retired past WB.

Decomposition:
- Package rv_pkg:
  - XLEN and RAW constants.
  - fwd_sel_e enum {FWD_RF, FWD_EX, FWD_MEM, FWD_WB}.
  - Packed struct of_out_t bundling the out_* payload.
- Sub-module of_fwd_mux: one operand's match/priority/select logic, combinational. Instantiated twice (rs1, rs2).

Test Plan:
- Reset: assert RST mid-cycle with out_valid=1 -> out_valid=0 and out_op1=0 immediately.
- EX forwarding: in_rs1=5, rf_rdata1=0x11, ex_rd=5, ex_we=1, ex_result=0xAA -> next cycle out_op1=0xAA.
- Priority: ex_rd=mem_rd=wb_rd=7, results 0x1/0x2/0x3 -> out_op2=0x1. Same with ex_we=0 -> 0x2.
- x0: in_rs1=0, ex_rd=0, ex_we=1, ex_result=0xFF -> out_op1=0.
- Load-use: ex_is_load=1, ex_rd=3, in_rs2=3, in_rs2_used=1 -> in_ready=0 and out_valid=0 next cycle. Next cycle EX clears, mem_rd=3, mem_result=0x55 -> capture with out_op2=0x55.
- Backpressure + flush:
  - Hold out_ready=0 for 3 cycles -> out_* stable, in_ready=0.
  - Then flush=1 with in_valid=1 -> out_valid=0 and nothing captured.
